// File: rtl/enemy_mover.sv
// Grid-scan enemy mover: each moving update walks the level grid, steps every enemy one cell
// in an LFSR-chosen direction (up to four tries), then a second pass commits moved cells.
module enemy_mover #(
  parameter int unsigned            GRID_W     = 40,
  parameter int unsigned            GRID_H     = 30,
  parameter int unsigned            X_BITS     = 6,
  parameter int unsigned            Y_BITS     = 5,
  parameter int unsigned            CELL_BITS  = 3,
  parameter logic [CELL_BITS-1:0]   AIR_CODE   = CELL_BITS'(0),
  parameter logic [CELL_BITS-1:0]   ENEMY_CODE = CELL_BITS'(4),
  parameter logic [CELL_BITS-1:0]   MOVED_CODE = CELL_BITS'(5),
  parameter int unsigned            PERIOD     = 200000,
  parameter logic [7:0]             LFSR_SEED  = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       done,
  output logic [X_BITS-1:0]          grid_x,
  output logic [Y_BITS-1:0]          grid_y,
  input  logic [CELL_BITS-1:0]       grid_out,
  output logic                       grid_write,
  output logic [CELL_BITS-1:0]       grid_in,
  output logic [X_BITS+Y_BITS-1:0]   enemy_count
);

  localparam int unsigned CW = X_BITS + Y_BITS;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [X_BITS-1:0] XMAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] YMAX = Y_BITS'(GRID_H - 1);
  localparam logic [TW-1:0]     TLOAD = TW'(PERIOD - 1);

  typedef enum logic [3:0] {
    WAIT, CHECK_TIMER, S_ADDR, S_READ, PICK_DIR, T_ADDR, T_READ, BLOCKED,
    W_NEW, W_OLD, F_ADDR, F_READ, F_WRITE, DONE
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [7:0]            r_lfsr;
  logic [X_BITS-1:0]     r_sx;
  logic [Y_BITS-1:0]     r_sy;
  logic [1:0]            r_dir;
  logic [1:0]            r_tries;
  logic                  r_oob;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic [X_BITS-1:0]     r_gx;
  logic [Y_BITS-1:0]     r_gy;
  logic                  r_gw;
  logic [CELL_BITS-1:0]  r_gi;
  logic [CW-1:0]         r_ecnt;

  logic                  w_fb;
  logic                  w_last;
  logic [X_BITS-1:0]     w_nx;
  logic [Y_BITS-1:0]     w_ny;
  logic [1:0]            w_dsel;
  logic                  w_oob;
  logic [X_BITS-1:0]     w_tx;
  logic [Y_BITS-1:0]     w_ty;

  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_last = (r_sx == XMAX) && (r_sy == YMAX);
  assign w_nx   = (r_sx == XMAX) ? '0 : r_sx + X_BITS'(1);
  assign w_ny   = (r_sx == XMAX) ? r_sy + Y_BITS'(1) : r_sy;
  // First try takes the LFSR direction; every retry rotates one step clockwise.
  assign w_dsel = (r_state == PICK_DIR) ? r_lfsr[1:0] : r_dir + 2'd1;

  always_comb begin
    w_oob = 1'b0;
    w_tx  = r_sx;
    w_ty  = r_sy;
    case (w_dsel)
      2'd0: begin w_oob = (r_sy == '0);  w_ty = r_sy - Y_BITS'(1); end
      2'd1: begin w_oob = (r_sx == XMAX); w_tx = r_sx + X_BITS'(1); end
      2'd2: begin w_oob = (r_sy == YMAX); w_ty = r_sy + Y_BITS'(1); end
      default: begin w_oob = (r_sx == '0); w_tx = r_sx - X_BITS'(1); end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT;
      r_timer <= TLOAD;
      r_lfsr  <= LFSR_SEED;
      r_sx    <= '0;
      r_sy    <= '0;
      r_dir   <= '0;
      r_tries <= '0;
      r_oob   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_gx    <= '0;
      r_gy    <= '0;
      r_gw    <= 1'b0;
      r_gi    <= AIR_CODE;
      r_ecnt  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      if (r_timer != '0) r_timer <= r_timer - TW'(1);
      r_done <= 1'b0;
      r_gw   <= 1'b0;
      case (r_state)
        WAIT: if (start) r_state <= CHECK_TIMER;
        CHECK_TIMER: begin
          if (r_timer != '0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_timer <= TLOAD;
            r_sx    <= '0;
            r_sy    <= '0;
            r_gx    <= '0;
            r_gy    <= '0;
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: r_state <= S_READ;
        S_READ: begin
          if (grid_out == ENEMY_CODE) begin
            r_cnt   <= r_cnt + CW'(1);
            r_state <= PICK_DIR;
          end else if (w_last) begin
            r_sx <= '0; r_sy <= '0; r_gx <= '0; r_gy <= '0;
            r_state <= F_ADDR;
          end else begin
            r_sx <= w_nx; r_sy <= w_ny; r_gx <= w_nx; r_gy <= w_ny;
            r_state <= S_ADDR;
          end
        end
        // Target address goes out on entry to T_ADDR so read data lands in T_READ.
        PICK_DIR: begin
          r_dir   <= w_dsel;
          r_tries <= '0;
          r_oob   <= w_oob;
          if (!w_oob) begin
            r_gx <= w_tx;
            r_gy <= w_ty;
          end
          r_state <= T_ADDR;
        end
        T_ADDR: r_state <= r_oob ? BLOCKED : T_READ;
        T_READ: begin
          if (grid_out == AIR_CODE) begin
            r_gw    <= 1'b1;
            r_gi    <= MOVED_CODE;
            r_state <= W_NEW;
          end else begin
            r_state <= BLOCKED;
          end
        end
        BLOCKED: begin
          if (r_tries == 2'd3) begin
            if (w_last) begin
              r_sx <= '0; r_sy <= '0; r_gx <= '0; r_gy <= '0;
              r_state <= F_ADDR;
            end else begin
              r_sx <= w_nx; r_sy <= w_ny; r_gx <= w_nx; r_gy <= w_ny;
              r_state <= S_ADDR;
            end
          end else begin
            r_dir   <= w_dsel;
            r_tries <= r_tries + 2'd1;
            r_oob   <= w_oob;
            if (!w_oob) begin
              r_gx <= w_tx;
              r_gy <= w_ty;
            end
            r_state <= T_ADDR;
          end
        end
        W_NEW: begin
          r_gw    <= 1'b1;
          r_gi    <= AIR_CODE;
          r_gx    <= r_sx;
          r_gy    <= r_sy;
          r_state <= W_OLD;
        end
        W_OLD: begin
          if (w_last) begin
            r_sx <= '0; r_sy <= '0; r_gx <= '0; r_gy <= '0;
            r_state <= F_ADDR;
          end else begin
            r_sx <= w_nx; r_sy <= w_ny; r_gx <= w_nx; r_gy <= w_ny;
            r_state <= S_ADDR;
          end
        end
        F_ADDR: r_state <= F_READ;
        // Second pass turns every MOVED marker back into a live enemy.
        F_READ: begin
          if (grid_out == MOVED_CODE) begin
            r_gw    <= 1'b1;
            r_gi    <= ENEMY_CODE;
            r_state <= F_WRITE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_ecnt  <= r_cnt;
            r_state <= DONE;
          end else begin
            r_sx <= w_nx; r_sy <= w_ny; r_gx <= w_nx; r_gy <= w_ny;
            r_state <= F_ADDR;
          end
        end
        F_WRITE: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_ecnt  <= r_cnt;
            r_state <= DONE;
          end else begin
            r_sx <= w_nx; r_sy <= w_ny; r_gx <= w_nx; r_gy <= w_ny;
            r_state <= F_ADDR;
          end
        end
        DONE:    r_state <= WAIT;
        default: r_state <= WAIT;
      endcase
    end
  end

  assign done        = r_done;
  assign grid_x      = r_gx;
  assign grid_y      = r_gy;
  assign grid_write  = r_gw;
  assign grid_in     = r_gi;
  assign enemy_count = r_ecnt;

endmodule

// File: tb/tb_enemy_mover.sv
// Bench for enemy_mover: behavioural grid/LFSR/timer model feeds a scoreboard queue,
// a negedge monitor pops and checks done timing, write count, grid contents and enemy_count.
module tb_enemy_mover;
  localparam int GW = 4, GH = 3, N = GW * GH, P = 8, CB = 3;
  localparam logic [2:0] AIR = 3'd0, WALL = 3'd1, ENEMY = 3'd4, MOVED = 3'd5;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic        done, grid_write;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out, grid_in;
  logic [10:0] enemy_count;

  always #5 clock = ~clock;

  enemy_mover #(.GRID_W(GW), .GRID_H(GH), .X_BITS(6), .Y_BITS(5), .CELL_BITS(CB),
                .AIR_CODE(AIR), .ENEMY_CODE(ENEMY), .MOVED_CODE(MOVED),
                .PERIOD(P), .LFSR_SEED(8'hA5)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
    .grid_write(grid_write), .grid_in(grid_in), .enemy_count(enemy_count));

  // level-grid RAM: synchronous read, write on grid_write, bulk load from the bench
  logic [2:0] mem [N];
  logic [2:0] ld  [N];
  logic       load = 1'b0;
  always @(posedge clock) begin
    if (load) for (int i = 0; i < N; i++) mem[i] <= ld[i];
    else if (grid_write && grid_x < GW && grid_y < GH) mem[int'(grid_y) * GW + int'(grid_x)] <= grid_in;
    grid_out <= (grid_x < GW && grid_y < GH) ? mem[int'(grid_y) * GW + int'(grid_x)] : 3'd7;
  end

  int cyc;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  typedef struct { int t; int cnt; int wr; logic [N*CB-1:0] g; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [2:0] mg [N];
  int t_base = 0, last_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l = 8'hA5;
    for (int k = 0; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic int timer_at(input int u);
    int e = u - t_base;
    return (e >= P - 1) ? 0 : P - 1 - e;
  endfunction

  function automatic logic [N*CB-1:0] pack_mg();
    logic [N*CB-1:0] r;
    for (int i = 0; i < N; i++) r[i*CB +: CB] = mg[i];
    return r;
  endfunction

  function automatic logic [N*CB-1:0] pack_mem();
    logic [N*CB-1:0] r;
    for (int i = 0; i < N; i++) r[i*CB +: CB] = mem[i];
    return r;
  endfunction

  // Reference: start high in cycle t; walk the grid adding each cell's cycle cost.
  task automatic model(input int t, output exp_t e);
    int tau, c, d0, d, nx, ny, ti;
    logic [7:0] l;
    e.wr = 0; e.cnt = 0; e.t = 0;
    if (timer_at(t + 1) != 0) begin
      e.t = t + 2; e.cnt = last_cnt; e.g = pack_mg();
      return;
    end
    t_base = t + 2;
    tau = t + 2;
    for (int i = 0; i < N; i++) begin
      if (mg[i] == ENEMY) begin
        e.cnt = e.cnt + 1;
        l = lfsr_at(tau + 2);
        d0 = int'(l[1:0]);
        c = tau + 3;
        for (int k = 0; k < 4; k++) begin
          d  = (d0 + k) % 4;
          nx = i % GW + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
          ny = i / GW + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) c += 2;
          else begin
            ti = ny * GW + nx;
            if (mg[ti] == AIR) begin
              mg[ti] = MOVED; mg[i] = AIR; e.wr += 2; c += 4;
              break;
            end else c += 3;
          end
        end
        tau = c;
      end else tau += 2;
    end
    for (int i = 0; i < N; i++) begin
      if (mg[i] == MOVED) begin mg[i] = ENEMY; e.wr += 1; tau += 3; end
      else tau += 2;
    end
    e.t = tau; last_cnt = e.cnt; e.g = pack_mg();
  endtask

  // monitor
  initial begin
    int wr_cnt = 0, cnt_exp = 0;
    bit cnt_pend = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        wr_cnt = 0; cnt_pend = 0;
      end else begin
        if (cnt_pend) begin chk("enemy_count", 64'(enemy_count), 64'(cnt_exp)); cnt_pend = 0; end
        if (grid_write) begin
          wr_cnt++;
          if (grid_x >= GW || grid_y >= GH) chk("write_addr_in_grid", 64'd0, 64'd1);
        end
        if (done) begin
          if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.t));
            chk("write_count", 64'(wr_cnt), 64'(e.wr));
            chk("grid", 64'(pack_mem()), 64'(e.g));
            cnt_exp = e.cnt; cnt_pend = 1;
          end
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic tick(); @(posedge clock); #1; endtask

  task automatic load_grid();
    for (int i = 0; i < N; i++) ld[i] = mg[i];
    load = 1'b1; tick(); load = 1'b0;
  endtask

  task automatic run_update();
    exp_t e;
    int b = 0;
    model(cyc, e);
    q.push_back(e);
    start = 1'b1; tick(); start = 1'b0;
    while (q.size() != 0 && b < 3000) begin tick(); b++; end
    if (q.size() != 0) begin chk("done_timeout", 64'd0, 64'd1); q.delete(); end
    tick();
  endtask

  task automatic wait_expired();
    int b = 0;
    while (timer_at(cyc + 1) != 0 && b < 100) begin tick(); b++; end
  endtask

  // wait until the timer has expired and the first pick lands on direction want
  task automatic wait_dir(input int pick_off, input int want);
    int b = 0;
    logic [7:0] l;
    bit ok = 0;
    while (b < 600) begin
      l = lfsr_at(cyc + pick_off);
      if (timer_at(cyc + 1) == 0 && int'(l[1:0]) == want) begin ok = 1; break; end
      tick(); b++;
    end
    if (!ok) chk("dir_search", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_grid_write", 64'(grid_write), 64'd0);
    chk("rst_grid_x", 64'(grid_x), 64'd0);
    chk("rst_grid_y", 64'(grid_y), 64'd0);
    chk("rst_grid_in", 64'(grid_in), 64'(AIR));
    chk("rst_enemy_count", 64'(enemy_count), 64'd0);
  endtask

  initial begin
    int r, tst;
    for (int i = 0; i < N; i++) mg[i] = AIR;
    reset = 1'b1;
    tick(); tick();
    load_grid();
    chk_reset_outs();
    reset = 1'b0;

    // timer still running: skipped update, 2 cycles, nothing written
    tick();
    run_update();

    // all air after expiry
    wait_expired();
    run_update();

    // single enemy at (1,1) moving right
    for (int i = 0; i < N; i++) mg[i] = AIR;
    mg[5] = ENEMY;
    load_grid();
    wait_dir(14, 1);
    run_update();
    chk("right_dst", 64'(mem[6]), 64'(ENEMY));
    chk("right_src", 64'(mem[5]), 64'(AIR));

    // corner enemy boxed in by walls: four failed tries, stays put
    for (int i = 0; i < N; i++) mg[i] = AIR;
    mg[0] = ENEMY; mg[1] = WALL; mg[4] = WALL;
    load_grid();
    wait_expired();
    run_update();
    chk("boxed_stay", 64'(mem[0]), 64'(ENEMY));

    // enemy at (1,0) moves down onto a cell scanned later; must not move twice
    for (int i = 0; i < N; i++) mg[i] = AIR;
    mg[1] = ENEMY;
    load_grid();
    wait_dir(6, 2);
    run_update();
    chk("down_dst", 64'(mem[5]), 64'(ENEMY));
    chk("down_src", 64'(mem[1]), 64'(AIR));

    // reset while in T_READ of enemy (1,1)
    for (int i = 0; i < N; i++) mg[i] = AIR;
    mg[5] = ENEMY;
    load_grid();
    wait_expired();
    tst = cyc;
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < tst + 16) tick();
    reset = 1'b1; tick();
    chk_reset_outs();
    reset = 1'b0; t_base = 0; last_cnt = 0;
    load_grid();
    repeat (P) tick();
    run_update();

    // random grids, random start spacing (some skipped, some moving)
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < N; i++) begin
          r = $urandom_range(0, 9);
          mg[i] = (r < 5) ? AIR : (r < 8) ? ENEMY : WALL;
        end
      end
      load_grid();
      repeat ($urandom_range(0, 10)) tick();
      run_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
